// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin merge of CHANNEL_NUMBER
// AXI-Stream inputs into one output stream through a 2-entry buffer.
// Ports: clk, rst_n (async, active low);
//   s_tvalid_i/s_tready_o/s_tlast_i per input bit i, s_tdata_i slice i
//   (optional s_tid_i/s_tdest_i/s_tuser_i slices likewise);
//   m_tvalid_o/m_tready_i/m_tdata_o/m_tlast_o (+ optional sidebands) merged.
module axis_packet_arbiter #(
   parameter int DATA_WIDTH           = 32,
   parameter int CHANNEL_NUMBER       = 5,
   parameter int CHANNEL_NUMBER_WIDTH =
      (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1,
   parameter int ID_WIDTH             = 4,
   parameter int DEST_WIDTH           = 4,
   parameter int USER_WIDTH           = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [CHANNEL_NUMBER-1:0]            s_tvalid_i,
   output logic [CHANNEL_NUMBER-1:0]            s_tready_o,
   input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] s_tdata_i,
   input  logic [CHANNEL_NUMBER-1:0]            s_tlast_i,
`ifdef TID_PRESENT
   input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]   s_tid_i,
   output logic [ID_WIDTH-1:0]                  m_tid_o,
`endif
`ifdef TDEST_PRESENT
   input  logic [CHANNEL_NUMBER*DEST_WIDTH-1:0] s_tdest_i,
   output logic [DEST_WIDTH-1:0]                m_tdest_o,
`endif
`ifdef TUSER_PRESENT
   input  logic [CHANNEL_NUMBER*USER_WIDTH-1:0] s_tuser_i,
   output logic [USER_WIDTH-1:0]                m_tuser_o,
`endif
   output logic                                 m_tvalid_o,
   input  logic                                 m_tready_i,
   output logic [DATA_WIDTH-1:0]                m_tdata_o,
   output logic                                 m_tlast_o
);

   localparam int CW = CHANNEL_NUMBER_WIDTH;

`ifdef TID_PRESENT
   localparam int IDW = ID_WIDTH;
`else
   localparam int IDW = 0 * ID_WIDTH;
`endif
`ifdef TDEST_PRESENT
   localparam int DSW = DEST_WIDTH;
`else
   localparam int DSW = 0 * DEST_WIDTH;
`endif
`ifdef TUSER_PRESENT
   localparam int USW = USER_WIDTH;
`else
   localparam int USW = 0 * USER_WIDTH;
`endif

   // Buffer entry layout: {user, dest, id, last, data}
   localparam int EW = DATA_WIDTH + 1 + IDW + DSW + USW;

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] grant_q, grant_d;
   logic [CW-1:0] rr_ptr_q, rr_ptr_d;
   logic [1:0]    count_q, count_d;
   logic [EW-1:0] ent0_q, ent0_d;
   logic [EW-1:0] ent1_q, ent1_d;

   logic          found;
   logic [CW-1:0] pick;
   logic          accept;
   logic          pop;
   logic [EW-1:0] in_ent;

   // First valid input scanning from rr_ptr upward with wrap.
   always_comb begin
      int j;
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int k = 0; k < CHANNEL_NUMBER; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= CHANNEL_NUMBER) j = j - CHANNEL_NUMBER;
         if (!found && s_tvalid_i[CW'(j)]) begin
            found = 1'b1;
            pick  = CW'(j);
         end
      end
   end

   assign accept = (state_q == LOCKED) && s_tvalid_i[grant_q] &&
                   (count_q != 2'd2);
   assign pop    = m_tvalid_o && m_tready_i;

   always_comb begin
      in_ent = '0;
      in_ent[DATA_WIDTH-1:0] = s_tdata_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
      in_ent[DATA_WIDTH]     = s_tlast_i[grant_q];
`ifdef TID_PRESENT
      in_ent[DATA_WIDTH+1 +: IDW] = s_tid_i[grant_q*ID_WIDTH +: ID_WIDTH];
`endif
`ifdef TDEST_PRESENT
      in_ent[DATA_WIDTH+1+IDW +: DSW] =
         s_tdest_i[grant_q*DEST_WIDTH +: DEST_WIDTH];
`endif
`ifdef TUSER_PRESENT
      in_ent[DATA_WIDTH+1+IDW+DSW +: USW] =
         s_tuser_i[grant_q*USER_WIDTH +: USER_WIDTH];
`endif
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      s_tready_o = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOCKED;
               grant_d = pick;
            end
         end
         LOCKED: begin
            s_tready_o[grant_q] = (count_q < 2'd2);
            // Lock holds through source gaps; only TLAST releases it.
            if (accept && s_tlast_i[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == CW'(CHANNEL_NUMBER - 1)) ?
                          '0 : grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift-style buffer: ent0 is always the head.
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      unique case ({accept, pop})
         2'b10: begin
            if (count_q == 2'd0) ent0_d = in_ent;
            else                 ent1_d = in_ent;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               ent0_d = ent1_q;
               ent1_d = in_ent;
            end else begin
               ent0_d = in_ent;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         count_q  <= '0;
         ent0_q   <= '0;
         ent1_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
      end
   end

   assign m_tvalid_o = (count_q != 2'd0);
   assign m_tdata_o  = ent0_q[DATA_WIDTH-1:0];
   assign m_tlast_o  = ent0_q[DATA_WIDTH];
`ifdef TID_PRESENT
   assign m_tid_o    = ent0_q[DATA_WIDTH+1 +: IDW];
`endif
`ifdef TDEST_PRESENT
   assign m_tdest_o  = ent0_q[DATA_WIDTH+1+IDW +: DSW];
`endif
`ifdef TUSER_PRESENT
   assign m_tuser_o  = ent0_q[DATA_WIDTH+1+IDW+DSW +: USW];
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed and randomized checks of the
// packet arbiter against a queue-based reference model.
module tb_axis_packet_arbiter;

   localparam int CN = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CN-1:0]    s_tvalid;
   logic [CN-1:0]    s_tready;
   logic [CN*DW-1:0] s_tdata;
   logic [CN-1:0]    s_tlast;
   logic             m_tvalid;
   logic             m_tready;
   logic [DW-1:0]    m_tdata;
   logic             m_tlast;

   axis_packet_arbiter #(
      .DATA_WIDTH(DW),
      .CHANNEL_NUMBER(CN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_tvalid_i(s_tvalid),
      .s_tready_o(s_tready),
      .s_tdata_i (s_tdata),
      .s_tlast_i (s_tlast),
      .m_tvalid_o(m_tvalid),
      .m_tready_i(m_tready),
      .m_tdata_o (m_tdata),
      .m_tlast_o (m_tlast)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus state
   beat_t       srcq[CN][$];
   bit          held[CN];
   bit          gap_block[CN];
   int unsigned vprob = 100;
   int unsigned rprob = 100;
   bit          force_rdy_lo = 1'b0;

   // Reference model state
   bit    mdl_locked;
   int    mdl_grant;
   int    mdl_rr;
   beat_t mdl_fifo[$];

   // Observations
   beat_t outlog[$];
   int    pop_cyc[$];
   int    accepted[CN];
   int    cyc = 0;

   // End-to-end scoreboard
   bit    sb_en = 1'b0;
   beat_t expq[CN][$];
   bit    prev_last = 1'b1;
   int    prev_src = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < CN; i++) begin
         if (srcq[i].size() > 0 &&
             (held[i] || (!gap_block[i] && $urandom_range(99) < vprob))) begin
            s_tvalid[i]         = 1'b1;
            s_tdata[i*DW +: DW] = srcq[i][0].data;
            s_tlast[i]          = srcq[i][0].last;
            held[i]             = 1'b1;
         end else begin
            s_tvalid[i]         = 1'b0;
            s_tdata[i*DW +: DW] = '0;
            s_tlast[i]          = 1'b0;
            held[i]             = 1'b0;
         end
      end
      m_tready = !force_rdy_lo && ($urandom_range(99) < rprob);
   endtask

   task automatic score(input beat_t b);
      int src;
      src = int'(b.data[31:24]);
      if (src >= CN || expq[src].size() == 0) begin
         check("sb_src", 64'(src), 64'hFF);
      end else begin
         check("sb_order", 64'(b), 64'(expq[src][0]));
         void'(expq[src].pop_front());
         if (!prev_last) check("sb_interleave", 64'(src), 64'(prev_src));
         prev_last = b.last;
         prev_src  = src;
      end
   endtask

   // One clock: compare at negedge, advance model, drive after posedge.
   task automatic step();
      logic [CN-1:0] exp_rdy;
      beat_t         b;
      bit            acc;
      int            g;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         mdl_locked = 1'b0;
         mdl_grant  = 0;
         mdl_rr     = 0;
         mdl_fifo.delete();
      end
      exp_rdy = '0;
      if (mdl_locked && mdl_fifo.size() < 2) exp_rdy[mdl_grant] = 1'b1;
      check("tready", 64'(s_tready), 64'(exp_rdy));
      check("tvalid", 64'(m_tvalid), 64'(mdl_fifo.size() != 0));
      if (mdl_fifo.size() != 0) begin
         check("tdata", 64'(m_tdata), 64'(mdl_fifo[0].data));
         check("tlast", 64'(m_tlast), 64'(mdl_fifo[0].last));
      end
      if (!rst_n) begin
         check("rst_tdata", 64'(m_tdata), 64'd0);
         check("rst_tlast", 64'(m_tlast), 64'd0);
      end else begin
         g   = mdl_grant;
         acc = mdl_locked && exp_rdy[g] && s_tvalid[g];
         if (mdl_fifo.size() != 0 && m_tready) begin
            b = mdl_fifo.pop_front();
            outlog.push_back(b);
            pop_cyc.push_back(cyc);
            if (sb_en) score(b);
         end
         if (acc) begin
            b.data = s_tdata[g*DW +: DW];
            b.last = s_tlast[g];
            mdl_fifo.push_back(b);
            accepted[g]++;
            void'(srcq[g].pop_front());
            held[g] = 1'b0;
            if (b.last) begin
               mdl_locked = 1'b0;
               mdl_rr     = (g + 1) % CN;
            end
         end else if (!mdl_locked) begin
            for (int k = 0; k < CN; k++) begin
               if (!mdl_locked && s_tvalid[(mdl_rr + k) % CN]) begin
                  mdl_locked = 1'b1;
                  mdl_grant  = (mdl_rr + k) % CN;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic bit busy();
      bit r;
      r = mdl_locked || (mdl_fifo.size() != 0);
      for (int i = 0; i < CN; i++) if (srcq[i].size() != 0) r = 1'b1;
      return r;
   endfunction

   task automatic drain(input string nm, input int budget);
      int b;
      b = budget;
      while (busy() && b > 0) begin
         step();
         b--;
      end
      if (b == 0) check({nm, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic load_pkt(input int ch, input int first, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = 32'(first + k);
         b.last = (k == len - 1);
         srcq[ch].push_back(b);
         if (sb_en) expq[ch].push_back(b);
      end
   endtask

   task automatic clear_log();
      outlog.delete();
      pop_cyc.delete();
   endtask

   task automatic log_at(input string nm, input int k, input logic [31:0] v);
      if (outlog.size() > k) check(nm, 64'(outlog[k].data), 64'(v));
      else check(nm, 64'hFFFF_FFFF_FFFF_FFFF, 64'(v));
   endtask

   initial begin
      int b;
      int base;
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      m_tready = 1'b0;
      for (int i = 0; i < CN; i++) begin
         held[i]      = 1'b0;
         gap_block[i] = 1'b0;
         accepted[i]  = 0;
      end

      // Reset with all inputs valid, then round-robin of 1-beat packets
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < CN; i++) load_pkt(i, 'hA0 + i, 1);
      drive();
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("first_grant", 64'(s_tready), 64'h01);
      b = 100;
      while (outlog.size() < 10 && b > 0) begin
         step();
         b--;
      end
      if (b == 0) check("rr_timeout", 64'd1, 64'd0);
      for (int k = 0; k < 6; k++) log_at("rr_order", k, 32'hA0 + (k % 5));
      for (int k = 1; k < 6 && k < pop_cyc.size(); k++)
         check("rr_bubble", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd2);
      drain("rr", 100);

      // Non-interleave: in[1] 4 beats against in[3] 2 beats
      clear_log();
      rprob = 70;
      load_pkt(1, 'h10, 4);
      load_pkt(3, 'h30, 2);
      drain("ni", 200);
      check("ni_len", 64'(outlog.size()), 64'd6);
      for (int k = 0; k < 6; k++)
         log_at("ni_order", k, (k < 4) ? 32'h10 + k : 32'h30 + k - 4);

      // Backpressure: downstream stalled for 6 cycles
      clear_log();
      rprob        = 100;
      force_rdy_lo = 1'b1;
      base         = accepted[0];
      load_pkt(0, 'h60, 5);
      drive();
      repeat (6) step();
      check("bp_accepted", 64'(accepted[0] - base), 64'd2);
      check("bp_tready", 64'(s_tready), 64'd0);
      force_rdy_lo = 1'b0;
      drain("bp", 200);
      check("bp_len", 64'(outlog.size()), 64'd5);
      for (int k = 0; k < 5; k++) log_at("bp_order", k, 32'h60 + k);

      // Source gap: in[2] stalls mid-packet while in[4] waits
      clear_log();
      base = accepted[2];
      load_pkt(2, 'h20, 4);
      b = 50;
      while (accepted[2] == base && b > 0) begin
         step();
         b--;
      end
      if (b == 0) check("gap_timeout", 64'd1, 64'd0);
      gap_block[2] = 1'b1;
      load_pkt(4, 'h40, 2);
      repeat (4) step();
      gap_block[2] = 1'b0;
      drain("gap", 200);
      for (int k = 0; k < 6; k++)
         log_at("gap_order", k, (k < 4) ? 32'h20 + k : 32'h40 + k - 4);

      // Move rr_ptr to 4, then reset in the middle of an in[2] packet
      clear_log();
      load_pkt(3, 'h35, 1);
      drain("rr4", 50);
      base = accepted[2];
      load_pkt(2, 'h50, 4);
      b = 50;
      while (accepted[2] - base < 2 && b > 0) begin
         step();
         b--;
      end
      if (b == 0) check("mid_timeout", 64'd1, 64'd0);
      check("mid_pre_tvalid", 64'(m_tvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      check("mid_rst_tready", 64'(s_tready), 64'd0);
      for (int i = 0; i < CN; i++) begin
         srcq[i].delete();
         held[i] = 1'b0;
      end
      drive();
      step();
      rst_n = 1'b1;
      clear_log();
      load_pkt(4, 'h74, 1);
      load_pkt(1, 'h71, 1);
      drive();
      drain("post_rst", 50);
      check("post_rst_len", 64'(outlog.size()), 64'd2);
      log_at("post_rst_order", 0, 32'h71);
      log_at("post_rst_order", 1, 32'h74);

      // Randomized traffic with end-to-end scoreboard
      sb_en = 1'b1;
      vprob = 60;
      rprob = 60;
      for (int p = 0; p < 8; p++)
         for (int i = 0; i < CN; i++)
            load_pkt(i, (i << 24) | (p << 8), 1 + int'($urandom_range(3)));
      drain("rand", 20000);
      for (int i = 0; i < CN; i++)
         check("sb_left", 64'(expq[i].size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Output-port stage of the mesh router. Merges the CHANNEL_NUMBER per-input-port streams that the route-computation stages steer toward one output direction into a single AXI-Stream output. Arbitration is round-robin and packet-granular: once an input wins, it keeps the output until its TLAST beat is accepted, so flits of different packets never interleave. A 2-entry output buffer decouples the upstream TREADY from the downstream link.

## Interface
- DATA_WIDTH, 32, TDATA width; equals the route-computation stages' DATA_WIDTH.
- CHANNEL_NUMBER, 5, number of competing inputs: local plus four mesh neighbours.
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), grant and pointer width.
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, 4, present only under TID_PRESENT / TDEST_PRESENT / TUSER_PRESENT; passed through unchanged.
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in, axis_if.s array, [CHANNEL_NUMBER], candidate streams; index i is input port i.
- out, axis_if.m, 1, merged output stream.

## Operation
- State: IDLE or LOCKED; grant[CHANNEL_NUMBER_WIDTH-1:0]; rr_ptr[CHANNEL_NUMBER_WIDTH-1:0]; 2-entry FIFO with count 0..2.
- All sideband fields present under the optional defines travel with TDATA through the FIFO, unchanged. TLAST is mandatory for this block.
- **IDLE:** all in[i].TREADY = 0. If any in[i].TVALID is high, grant takes the first valid index scanning rr_ptr, rr_ptr+1, … with wrap at CHANNEL_NUMBER−1 → 0. The state moves to LOCKED on the next edge. With no valid input, nothing changes.
- **LOCKED:**
  - in[grant].TREADY = (count < 2); every other in[j].TREADY = 0.
  - A beat is accepted when in[grant].TVALID && in[grant].TREADY; the beat is pushed into the FIFO.
  - If the accepted beat has TLAST = 1: state → IDLE, rr_ptr ← (grant == CHANNEL_NUMBER−1) ? 0 : grant+1.
  - TVALID deasserting mid-packet keeps the lock; the arbiter waits indefinitely.
- **FIFO:**
  - out.TVALID = (count != 0); out carries the head entry.
  - Pop on out.TVALID && out.TREADY.
  - A push and a pop in the same cycle leave count unchanged, including at count = 2; the head is replaced correctly.
  - Ordering is strictly FIFO.
- The block never inspects TDATA. Packet boundaries come from TLAST alone.

## Timing
- Reset (asynchronous, rst_n low): state = IDLE, rr_ptr = 0, grant = 0, count = 0, out.TVALID = 0, out.TDATA = 0, out.TLAST = 0, all in[i].TREADY = 0. Reset mid-packet discards the lock and the buffered beats.
- Arbitration bubble: one cycle. An input raising TVALID in cycle t while in IDLE sees TREADY in cycle t+1 at the earliest.
- Latency: a beat accepted at edge t+1 is on out with TVALID = 1 in cycle t+1 after that edge, i.e. one register stage.
- Throughput: one beat per cycle while locked and out.TREADY = 1.
- Back-to-back packets: one idle cycle between packets (the TLAST edge returns to IDLE, then the re-arbitration edge).
- Single-beat packet (TLAST on the first beat): lock and release within LOCKED for exactly one accepted beat.
- out.TREADY held low: at most 2 beats are accepted, then in[grant].TREADY = 0. Data and TLAST stay stable while out.TVALID = 1 and out.TREADY = 0.
- rr_ptr changes only on an accepted TLAST beat.

## Test plan
- **Reset:** hold rst_n low for 3 cycles with all inputs valid → all outputs 0, no TREADY. Release reset → first grant goes to in[0].
- **Round-robin:** all 5 inputs each present 1-beat packets (TDATA = 0xA0+i, TLAST = 1) continuously → out order is A0, A1, A2, A3, A4, A0, with one bubble cycle between beats.
- **Non-interleave:** in[1] sends a 4-beat packet 0x10..0x13 and in[3] sends 0x30..0x31 at the same time → out = 10, 11, 12, 13, 30, 31. in[3].TREADY stays 0 until 0x13 is accepted.
- **Backpressure:** out.TREADY = 0 for 6 cycles during a 5-beat packet → exactly 2 beats are accepted, then TREADY drops. Release → all 5 beats are delivered in order with no loss or duplication.
- **Gap in source:** in[2].TVALID drops for 3 cycles mid-packet while in[4] is valid → the lock stays on in[2]; in[4] is served only after in[2]'s TLAST.
- **Reset mid-packet:** pulse rst_n low after 2 of 4 beats → out.TVALID goes to 0 immediately. After release, arbitration restarts from rr_ptr = 0.
